// File: rtl/oled_spi_rx.sv
// oled_spi_rx: panel-side receiver for the OLED SPI header.
// Synchronizes the SPI pins into clk and reassembles bytes. Each byte is
// classified as a command or as pixel data. Commands update the SSD1306
// page-mode address state; data bytes become framebuffer write strobes.
//
// state         | meaning
// --------------|----------------------------------------------------------
// bit_cnt 0..7  | number of bits already shifted into the current byte
// arg_cnt 0..2  | command argument bytes still to be swallowed undecoded
// page / col    | page-mode write pointer; col is reduced modulo NUM_COLS on use
module oled_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_PAGES   = 4,
    parameter int NUM_COLS    = 128
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cs_n,
    input  logic                                  sclk,
    input  logic                                  sdo,
    input  logic                                  dc,
    input  logic                                  res,
    input  logic                                  vdd,
    input  logic                                  vbat,
    output logic                                  byte_valid,
    output logic [7:0]                            byte_data,
    output logic                                  byte_is_data,
    output logic                                  fb_we,
    output logic [$clog2(NUM_PAGES*NUM_COLS)-1:0] fb_addr,
    output logic [7:0]                            fb_wdata,
    output logic                                  display_on,
    output logic                                  powered,
    output logic [15:0]                           cmd_count
);

    localparam int          ADDR_W = $clog2(NUM_PAGES*NUM_COLS);
    localparam logic [31:0] NCOLS  = NUM_COLS;
    localparam logic [31:0] NPAGES = NUM_PAGES;

    // Pin bundle order: {vbat, vdd, res, dc, sdo, sclk, cs_n}.
    // Idle values: supplies off, panel out of reset, chip deselected, sclk low.
    localparam logic [6:0] SYNC_RST = 7'b111_0001;

    logic [6:0] sync_q [SYNC_STAGES];
    logic [6:0] sync_out;
    logic       cs_n_s, sclk_s, sdo_s, dc_s, res_s, vdd_s, vbat_s;
    logic       sclk_prev;
    logic       rise;

    logic [6:0]  shift;
    logic [2:0]  bit_cnt;
    logic [1:0]  arg_cnt;
    logic [2:0]  page;
    logic [6:0]  col;
    logic [7:0]  nb;
    logic [31:0] col_eff;
    logic [6:0]  col_next;
    logic [2:0]  page_sel;

    // Multi-stage synchronizer for every asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {vbat, vdd, res, dc, sdo, sclk, cs_n};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign cs_n_s   = sync_out[0];
    assign sclk_s   = sync_out[1];
    assign sdo_s    = sync_out[2];
    assign dc_s     = sync_out[3];
    assign res_s    = sync_out[4];
    assign vdd_s    = sync_out[5];
    assign vbat_s   = sync_out[6];

    assign powered  = ~vdd_s & ~vbat_s;

    // Previous synchronized sclk sample for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) sclk_prev <= 1'b0;
        else     sclk_prev <= sclk_s;
    end

    assign rise     = sclk_s & ~sclk_prev;
    assign nb       = {shift, sdo_s};
    assign col_eff  = 32'(col) % NCOLS;
    assign col_next = (col_eff == NCOLS - 32'd1) ? 7'd0 : 7'(col_eff + 32'd1);
    assign page_sel = 3'(32'(nb[2:0]) % NPAGES);

    // Byte assembly, command decode and framebuffer write generation.
    // The byte completes on the edge that consumes the 8th rise, so the
    // strobes and the address update land together in the byte_valid cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift        <= '0;
            bit_cnt      <= '0;
            arg_cnt      <= '0;
            page         <= '0;
            col          <= '0;
            byte_valid   <= 1'b0;
            byte_data    <= '0;
            byte_is_data <= 1'b0;
            fb_we        <= 1'b0;
            fb_addr      <= '0;
            fb_wdata     <= '0;
            display_on   <= 1'b0;
            cmd_count    <= '0;
        end else begin
            byte_valid <= 1'b0;
            fb_we      <= 1'b0;
            if (!res_s) begin
                // Panel held in reset: byte path ignored, cmd_count kept.
                shift      <= '0;
                bit_cnt    <= '0;
                arg_cnt    <= '0;
                page       <= '0;
                col        <= '0;
                display_on <= 1'b0;
            end else if (cs_n_s) begin
                bit_cnt <= '0;
            end else if (rise) begin
                shift   <= nb[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid   <= 1'b1;
                    byte_data    <= nb;
                    byte_is_data <= dc_s;
                    if (dc_s) begin
                        fb_we    <= 1'b1;
                        fb_addr  <= ADDR_W'(32'(page) * NCOLS + col_eff);
                        fb_wdata <= nb;
                        col      <= col_next;
                        arg_cnt  <= '0;
                    end else begin
                        if (cmd_count != 16'hFFFF) cmd_count <= cmd_count + 16'd1;
                        if (arg_cnt != 2'd0) begin
                            arg_cnt <= arg_cnt - 2'd1;
                        end else if (nb[7:4] == 4'h0) begin
                            col[3:0] <= nb[3:0];
                        end else if (nb[7:4] == 4'h1) begin
                            col[6:4] <= nb[2:0];
                        end else if (nb[7:3] == 5'b1011_0) begin
                            page <= page_sel;
                        end else begin
                            case (nb)
                                8'hAE: display_on <= 1'b0;
                                8'hAF: display_on <= 1'b1;
                                8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                                8'hD5, 8'hD9, 8'hDA, 8'hDB: arg_cnt <= 2'd1;
                                8'h21, 8'h22: arg_cnt <= 2'd2;
                                default: ;
                            endcase
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Bench for oled_spi_rx: directed scenarios plus a randomized byte stream,
// all checked against a transaction-level model of the panel state.
module tb_oled_spi_rx;

    localparam int NCOLS  = 128;
    localparam int NPAGES = 4;

    logic       clk = 1'b0;
    logic       rst, cs_n, sclk, sdo, dc, res, vdd, vbat;
    logic       byte_valid, byte_is_data, fb_we, display_on, powered;
    logic [7:0] byte_data, fb_wdata;
    logic [8:0] fb_addr;
    logic [15:0] cmd_count;

    oled_spi_rx dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .sdo(sdo), .dc(dc),
        .res(res), .vdd(vdd), .vbat(vbat),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .display_on(display_on), .powered(powered), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor
    int         sb_n = 0;
    int         we_n = 0;
    logic [7:0] last_data;
    logic       last_isd, last_we;
    logic [8:0] last_addr;
    logic [7:0] last_wd;

    always @(negedge clk) begin
        if (byte_valid) begin
            sb_n++;
            last_data = byte_data;
            last_isd  = byte_is_data;
            last_we   = fb_we;
        end
        if (fb_we) begin
            we_n++;
            last_addr = fb_addr;
            last_wd   = fb_wdata;
        end
    end

    // Reference model of the panel state
    int m_page, m_col, m_disp, m_cnt, m_arg;

    task automatic model_panel_reset();
        m_page = 0; m_col = 0; m_disp = 0; m_arg = 0;
    endtask

    task automatic model_byte(input bit is_d, input logic [7:0] b,
                              output bit exp_we, output int exp_addr);
        int v;
        v = int'(b);
        exp_we   = 1'b0;
        exp_addr = 0;
        if (is_d) begin
            exp_we   = 1'b1;
            exp_addr = m_page * NCOLS + (m_col % NCOLS);
            m_col    = ((m_col % NCOLS) + 1) % NCOLS;
            m_arg    = 0;
        end else begin
            if (m_cnt < 65535) m_cnt++;
            if (m_arg > 0) m_arg--;
            else if (v <= 8'h0F) m_col = (m_col & 'h70) | (v & 'h0F);
            else if (v <= 8'h1F) m_col = (m_col & 'h0F) | ((v & 7) * 16);
            else if (v >= 8'hB0 && v <= 8'hB7) m_page = (v & 7) % NPAGES;
            else if (v == 8'hAE) m_disp = 0;
            else if (v == 8'hAF) m_disp = 1;
            else if (v == 8'h21 || v == 8'h22) m_arg = 2;
            else if (v == 8'h20 || v == 8'h81 || v == 8'h8D || v == 8'hA8 || v == 8'hD3 ||
                     v == 8'hD5 || v == 8'hD9 || v == 8'hDA || v == 8'hDB) m_arg = 1;
        end
    endtask

    // SPI mode-0 bit driver, sclk = clk/8
    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sdo = b[7-i];
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input bit is_d, input logic [7:0] b);
        int sb0, we0, ea;
        bit ew;
        sb0 = sb_n;
        we0 = we_n;
        cs_n = 1'b0;
        dc   = is_d;
        #20;
        send_bits(b, 8);
        repeat (8) @(negedge clk);
        model_byte(is_d, b, ew, ea);
        chk("strobe_count", 32'(sb_n - sb0), 32'd1);
        chk("byte_data", 32'(last_data), 32'(b));
        chk("byte_is_data", 32'(last_isd), 32'(is_d));
        chk("fb_we_count", 32'(we_n - we0), 32'(ew));
        chk("fb_we_with_valid", 32'(last_we), 32'(ew));
        if (ew) begin
            chk("fb_addr", 32'(last_addr), 32'(ea));
            chk("fb_wdata", 32'(last_wd), 32'(b));
        end
        chk("display_on", 32'(display_on), 32'(m_disp));
        chk("cmd_count", 32'(cmd_count), 32'(m_cnt));
    endtask

    initial begin
        int sb0, cnt0;
        logic [7:0] rb;
        int r;

        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; sdo = 1'b0; dc = 1'b0;
        res = 1'b1; vdd = 1'b1; vbat = 1'b1;
        model_panel_reset();
        m_cnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_byte_valid", 32'(byte_valid), 0);
        chk("rst_byte_data", 32'(byte_data), 0);
        chk("rst_fb_we", 32'(fb_we), 0);
        chk("rst_fb_addr", 32'(fb_addr), 0);
        chk("rst_display_on", 32'(display_on), 0);
        chk("rst_powered", 32'(powered), 0);
        chk("rst_cmd_count", 32'(cmd_count), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Page/column setup then one data write
        send_byte(0, 8'hAF);
        send_byte(0, 8'hB2);
        send_byte(0, 8'h05);
        send_byte(0, 8'h13);
        chk("tp1_cmd_count", 32'(cmd_count), 32'd4);
        send_byte(1, 8'hA5);
        chk("tp1_addr", 32'(last_addr), 32'd309);

        // Column wrap inside page 1
        send_byte(0, 8'hB1);
        send_byte(0, 8'h0E);
        send_byte(0, 8'h17);
        send_byte(1, 8'h11);
        chk("wrap_addr0", 32'(last_addr), 32'd254);
        send_byte(1, 8'h22);
        chk("wrap_addr1", 32'(last_addr), 32'd255);
        send_byte(1, 8'h33);
        chk("wrap_addr2", 32'(last_addr), 32'd128);

        // Argument byte is not decoded as a page command
        send_byte(0, 8'hB0);
        send_byte(0, 8'h04);
        send_byte(0, 8'h10);
        cnt0 = int'(cmd_count);
        send_byte(0, 8'h81);
        send_byte(0, 8'hB3);
        send_byte(1, 8'h7E);
        chk("arg_addr", 32'(last_addr), 32'd4);
        chk("arg_cmd_delta", 32'(int'(cmd_count) - cnt0), 32'd2);

        // Partial byte discarded when cs_n rises
        sb0 = sb_n;
        cs_n = 1'b0; dc = 1'b0;
        #20;
        send_bits(8'hFF, 5);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("partial_no_strobe", 32'(sb_n - sb0), 0);
        send_byte(0, 8'h3C);

        // Panel reset mid-byte
        send_byte(0, 8'hB3);
        send_byte(0, 8'h08);
        send_byte(0, 8'h12);
        send_byte(0, 8'hAF);
        sb0  = sb_n;
        cnt0 = int'(cmd_count);
        cs_n = 1'b0; dc = 1'b0;
        #20;
        send_bits(8'h55, 3);
        @(negedge clk) res = 1'b0;
        send_bits(8'hFF, 1);
        repeat (2) @(negedge clk);
        res = 1'b1;
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        model_panel_reset();
        chk("res_no_strobe", 32'(sb_n - sb0), 0);
        chk("res_display_off", 32'(display_on), 0);
        chk("res_cmd_kept", 32'(cmd_count), 32'(cnt0));
        send_byte(1, 8'h99);
        chk("res_addr_zero", 32'(last_addr), 0);

        // Randomized command/data stream
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 11));
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                cs_n = 1'b1;
                repeat ($urandom_range(2, 6)) @(negedge clk);
            end
            case (r)
                0, 1, 2, 3: send_byte(1, rb);
                4:  send_byte(0, {4'h0, rb[3:0]});
                5:  send_byte(0, {4'h1, rb[3:0]});
                6:  send_byte(0, {5'b10110, rb[2:0]});
                7:  send_byte(0, rb[0] ? 8'hAF : 8'hAE);
                8:  send_byte(0, rb[0] ? 8'h21 : 8'h22);
                9:  send_byte(0, rb[0] ? 8'h81 : 8'hD5);
                default: send_byte(0, rb);
            endcase
        end

        // Synchronous reset during the 4th bit
        send_byte(0, 8'hAF);
        cs_n = 1'b0; dc = 1'b0;
        #20;
        send_bits(8'hF0, 3);
        sdo = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("rst2_byte_valid", 32'(byte_valid), 0);
        chk("rst2_byte_data", 32'(byte_data), 0);
        chk("rst2_byte_is_data", 32'(byte_is_data), 0);
        chk("rst2_fb_we", 32'(fb_we), 0);
        chk("rst2_fb_addr", 32'(fb_addr), 0);
        chk("rst2_fb_wdata", 32'(fb_wdata), 0);
        chk("rst2_display_on", 32'(display_on), 0);
        chk("rst2_cmd_count", 32'(cmd_count), 0);
        rst = 1'b0;
        cs_n = 1'b1;
        model_panel_reset();
        m_cnt = 0;
        repeat (4) @(negedge clk);
        send_byte(0, 8'hAE);
        chk("rst2_after_cmd", 32'(cmd_count), 32'd1);

        // Supply enables through the synchronizer
        @(negedge clk);
        vdd = 1'b0; vbat = 1'b0;
        @(negedge clk);
        chk("powered_early", 32'(powered), 0);
        @(negedge clk);
        chk("powered", 32'(powered), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
